// File: rtl/imul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imul_share_arbiter
//  Purpose  : Shares one multi-cycle integer multiplier between NREQ
//             requesters. Round-robin grant, one operation in flight, result
//             held on the response bus until the owning requester accepts it.
//  Ports    : i_clk/i_nrst        clock, synchronous active-low reset
//             i_req_*             per-requester request channel (packed)
//             o_req_ready         one-hot grant, only while idle
//             o_mul_*             latched operands/flags + start pulse
//             i_mul_res/valid     multiplier result channel
//             o_resp_valid/data   response to owner, i_resp_ready accepts
//             i_flush             per-requester cancel
//             o_err               one-cycle pulse when an op times out
//  Revision : 1.0  initial release
// ============================================================================
module imul_share_arbiter #(
    parameter int NREQ        = 2,
    parameter int XLEN        = 64,
    parameter int MUL_TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*XLEN-1:0] i_req_a1,
    input  logic [NREQ*XLEN-1:0] i_req_a2,
    input  logic [NREQ-1:0]      i_req_unsign,
    input  logic [NREQ-1:0]      i_req_high,
    input  logic [NREQ-1:0]      i_req_rv32,
    input  logic [NREQ-1:0]      i_flush,
    output logic                 o_mul_ena,
    output logic [XLEN-1:0]      o_mul_a1,
    output logic [XLEN-1:0]      o_mul_a2,
    output logic                 o_mul_unsign,
    output logic                 o_mul_high,
    output logic                 o_mul_rv32,
    input  logic [XLEN-1:0]      i_mul_res,
    input  logic                 i_mul_valid,
    output logic [NREQ-1:0]      o_resp_valid,
    input  logic [NREQ-1:0]      i_resp_ready,
    output logic [XLEN-1:0]      o_resp_data,
    output logic                 o_err
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CW = $clog2(MUL_TIMEOUT + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    localparam logic [c_IW-1:0] c_LAST_REQ = c_IW'(NREQ - 1);
    // The counter is 0 in the first WAIT cycle, so the MUL_TIMEOUT-th WAIT
    // cycle without a result is the one where it reads MUL_TIMEOUT-1.
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(MUL_TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_IW-1:0] r_rr_ptr;
    logic [c_IW-1:0] r_tag;
    logic [c_CW-1:0] r_cnt;
    logic            r_cancel;
    logic [XLEN-1:0] r_a1;
    logic [XLEN-1:0] r_a2;
    logic            r_unsign;
    logic            r_high;
    logic            r_rv32;
    logic [XLEN-1:0] r_resp_data;

    logic [NREQ-1:0] w_req_eff;
    logic            w_found;
    logic [c_IW-1:0] w_winner;
    logic [c_IW:0]   w_idx;
    logic            w_take;
    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_resp_oh;
    logic            w_err;

    // Round-robin search starting at r_rr_ptr; a requester flushing this
    // cycle is not eligible.
    always_comb begin
        w_req_eff = i_req_valid & ~i_flush;
        w_found   = 1'b0;
        w_winner  = '0;
        w_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (c_IW + 1)'(k);
            if (w_idx >= (c_IW + 1)'(NREQ)) begin
                w_idx = w_idx - (c_IW + 1)'(NREQ);
            end
            if (!w_found && w_req_eff[w_idx[c_IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_IW-1:0];
            end
        end
    end

    // Grant is only offered in IDLE and out of reset, so valid&ready reduces
    // to "a winner exists while idle".
    assign w_take = (r_state == c_ST_IDLE) && w_found && i_nrst;

    always_comb begin
        w_grant = '0;
        if (w_take) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_resp_oh = '0;
        if (r_state == c_ST_RESP) begin
            w_resp_oh[r_tag] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_take) begin
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // A flush arriving together with the result still discards it.
                if (i_mul_valid) begin
                    w_state_nxt = (r_cancel || i_flush[r_tag]) ? c_ST_IDLE : c_ST_RESP;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_err       = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_RESP: begin
                if (i_resp_ready[r_tag] || i_flush[r_tag]) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state     <= c_ST_IDLE;
            r_rr_ptr    <= '0;
            r_tag       <= '0;
            r_cnt       <= '0;
            r_cancel    <= 1'b0;
            r_a1        <= '0;
            r_a2        <= '0;
            r_unsign    <= 1'b0;
            r_high      <= 1'b0;
            r_rv32      <= 1'b0;
            r_resp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_take) begin
                        r_a1     <= i_req_a1[int'(w_winner)*XLEN +: XLEN];
                        r_a2     <= i_req_a2[int'(w_winner)*XLEN +: XLEN];
                        r_unsign <= i_req_unsign[w_winner];
                        r_high   <= i_req_high[w_winner];
                        r_rv32   <= i_req_rv32[w_winner];
                        r_tag    <= w_winner;
                        r_cancel <= 1'b0;
                        r_rr_ptr <= (w_winner == c_LAST_REQ) ? '0 : w_winner + c_IW'(1);
                    end
                end
                c_ST_ISSUE: begin
                    r_cnt <= '0;
                    if (i_flush[r_tag]) begin
                        r_cancel <= 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    r_cnt <= r_cnt + c_CW'(1);
                    if (i_flush[r_tag]) begin
                        r_cancel <= 1'b1;
                    end
                    if (i_mul_valid) begin
                        r_resp_data <= i_mul_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_req_ready  = w_grant;
    assign o_mul_ena    = (r_state == c_ST_ISSUE);
    assign o_mul_a1     = r_a1;
    assign o_mul_a2     = r_a2;
    assign o_mul_unsign = r_unsign;
    assign o_mul_high   = r_high;
    assign o_mul_rv32   = r_rv32;
    assign o_resp_valid = w_resp_oh;
    assign o_resp_data  = r_resp_data;
    assign o_err        = w_err;

endmodule
`default_nettype wire

// File: tb/tb_imul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imul_share_arbiter
//  Purpose  : Self-checking bench for imul_share_arbiter (NREQ=2, XLEN=64).
//             A multiplier stub answers start pulses after a chosen latency;
//             a scoreboard queue holds the expected owner/data of every
//             granted request and a negedge monitor checks responses and
//             round-robin grants against a high-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imul_share_arbiter;

    localparam int NREQ = 2;
    localparam int XLEN = 64;

    typedef struct {
        int          owner;
        logic [63:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic [NREQ-1:0]      req_valid, req_ready, req_unsign, req_high, req_rv32;
    logic [NREQ-1:0]      flush, resp_valid, resp_ready;
    logic [NREQ*XLEN-1:0] req_a1, req_a2;
    logic                 mul_ena, mul_unsign, mul_high, mul_rv32, mul_valid, err;
    logic [XLEN-1:0]      mul_a1, mul_a2, mul_res, resp_data;
    logic                 stub_valid, man_valid;
    logic [XLEN-1:0]      stub_res, man_res;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic mdl_busy = 1'b0;
    int   mdl_rr   = 0;
    logic arb_chk  = 1'b0;
    logic [NREQ-1:0] hs_mask = '0;
    logic stub_en   = 1'b1;
    logic stub_rand = 1'b0;
    int   stub_lat  = 4;

    always #5 clk = ~clk;

    assign mul_valid = stub_valid | man_valid;
    assign mul_res   = man_valid ? man_res : stub_res;

    imul_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .MUL_TIMEOUT(16)) dut (
        .i_clk(clk), .i_nrst(nrst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a1(req_a1), .i_req_a2(req_a2),
        .i_req_unsign(req_unsign), .i_req_high(req_high), .i_req_rv32(req_rv32),
        .i_flush(flush),
        .o_mul_ena(mul_ena), .o_mul_a1(mul_a1), .o_mul_a2(mul_a2),
        .o_mul_unsign(mul_unsign), .o_mul_high(mul_high), .o_mul_rv32(mul_rv32),
        .i_mul_res(mul_res), .i_mul_valid(mul_valid),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_data(resp_data), .o_err(err)
    );

    // Reference product: MULW returns the sign-extended low word, otherwise
    // the low or high half of the full 128-bit product.
    function automatic logic [63:0] mul_ref(input logic [63:0] a, input logic [63:0] b,
                                            input logic u, input logic h, input logic w);
        logic [127:0] p;
        logic [63:0]  pl;
        if (w) begin
            pl = a * b;
            return {{32{pl[31]}}, pl[31:0]};
        end
        if (u) p = {64'b0, a} * {64'b0, b};
        else   p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        return h ? p[127:64] : p[63:0];
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst      = 1'b0;
        req_valid = '0;
        flush     = '0;
        resp_ready = '0;
        man_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        req_valid  = '0;
        resp_ready = '1;
        while (sb_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        check("drain_done", 256'(sb_q.size() == 0), 256'(1));
        resp_ready = '0;
    endtask

    // Multiplier stub: answers each start pulse L cycles later, computing the
    // product from the operands the arbiter actually presents.
    initial begin
        logic [63:0] sa1, sa2;
        logic        su, sh, sw;
        int          lat;
        stub_valid = 1'b0;
        stub_res   = '0;
        forever begin
            @(posedge clk);
            if (stub_en && mul_ena === 1'b1) begin
                sa1 = mul_a1; sa2 = mul_a2;
                su = mul_unsign; sh = mul_high; sw = mul_rv32;
                lat = stub_rand ? int'($urandom_range(1, 6)) : stub_lat;
                repeat (lat - 1) @(posedge clk);
                #1;
                stub_valid = 1'b1;
                stub_res   = mul_ref(sa1, sa2, su, sh, sw);
                @(posedge clk);
                #1 stub_valid = 1'b0;
            end
        end
    end

    // Monitor / scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] eff, exp_rdy;
        exp_t e;
        int   j;
        hs_mask = '0;
        if (!nrst) begin
            sb_q.delete();
            mdl_busy = 1'b0;
            mdl_rr   = 0;
        end else begin
            eff     = req_valid & ~flush;
            exp_rdy = '0;
            if (!mdl_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (mdl_rr + k) % NREQ;
                    if (exp_rdy == '0 && eff[j]) exp_rdy[j] = 1'b1;
                end
            end
            if (arb_chk) check("arb_ready", 256'(req_ready), 256'(exp_rdy));
            hs_mask = req_ready & req_valid;
            for (int i = 0; i < NREQ; i++) begin
                if (hs_mask[i]) begin
                    e.owner = i;
                    e.data  = mul_ref(req_a1[i*XLEN +: XLEN], req_a2[i*XLEN +: XLEN],
                                      req_unsign[i], req_high[i], req_rv32[i]);
                    sb_q.push_back(e);
                    mdl_rr   = (i + 1) % NREQ;
                    mdl_busy = 1'b1;
                end
            end
            if (resp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    check("resp_unexpected", 256'(resp_valid), 256'(0));
                end else begin
                    e = sb_q[0];
                    check("resp_owner", 256'(resp_valid), 256'(1) << e.owner);
                    check("resp_data", 256'(resp_data), 256'(e.data));
                    if (resp_ready[e.owner] || flush[e.owner]) begin
                        void'(sb_q.pop_front());
                        mdl_busy = 1'b0;
                    end
                end
            end else if (sb_q.size() > 0 && flush[sb_q[0].owner]) begin
                void'(sb_q.pop_front());
                mdl_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] pending;
        logic            found;
        int              t;
        nrst = 1'b0; req_valid = '0; flush = '0; resp_ready = '0;
        req_a1 = '0; req_a2 = '0; req_unsign = '0; req_high = '0; req_rv32 = '0;
        man_valid = 1'b0; man_res = '0;

        // Reset state: outputs quiet even with requests pending.
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 256'({req_ready, mul_ena, mul_a1, mul_a2, mul_unsign, mul_high,
                                     mul_rv32, resp_valid, resp_data, err}), 256'(0));
        do_reset();

        // Both requesters valid continuously: grants alternate from 0.
        arb_chk = 1'b1;
        req_a1 = {64'd3, 64'd5}; req_a2 = {64'd11, 64'd13};
        req_valid = 2'b11; resp_ready = 2'b11;
        for (int g = 0; g < 4; g++) begin
            found = 1'b0; t = 0;
            while (!found && t < 40) begin
                @(negedge clk);
                if (req_ready != '0) begin
                    found = 1'b1;
                    check($sformatf("rr_grant%0d", g), 256'(req_ready), 256'(1) << (g % 2));
                end
                t++;
                @(posedge clk); #1;
            end
            if (!found) check($sformatf("rr_grant%0d_timeout", g), 256'(0), 256'(1));
        end
        drain();
        do_reset();

        // 7*6 unsigned, latency 4, owner holds off accepting for 5 cycles.
        req_a1 = {64'd0, 64'd7}; req_a2 = {64'd0, 64'd6};
        req_unsign = 2'b01; req_high = '0; req_rv32 = '0; resp_ready = '0;
        req_valid = 2'b01;
        @(negedge clk);
        check("t2_grant_T0", 256'(req_ready), 256'(2'b01));
        tick();
        req_valid = 2'b10;
        req_a1[127:64] = 64'hFFFF_FFFF_FFFF_FFFD; req_a2[127:64] = 64'd9;
        @(negedge clk);
        check("t2_issue_T1", 256'({mul_ena, mul_a1, mul_a2, mul_unsign, mul_high, mul_rv32}),
              256'({1'b1, 64'd7, 64'd6, 3'b100}));
        tick();
        @(negedge clk);
        check("t2_ena_T2", 256'(mul_ena), 256'(0));
        for (int c = 3; c <= 5; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("t2_no_resp_T%0d", c), 256'(resp_valid), 256'(0));
        end
        for (int c = 6; c <= 10; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("t2_resp_T%0d", c), 256'({resp_valid, resp_data, req_ready}),
                  256'({2'b01, 64'd42, 2'b00}));
        end
        tick();
        resp_ready = 2'b01;
        tick();
        @(negedge clk);
        check("t2_next_grant", 256'(req_ready), 256'(2'b10));
        tick();
        drain();
        do_reset();

        // Flush of requester 1 during WAIT: result dropped, req0 served after.
        arb_chk = 1'b0;
        req_a1 = {64'd100, 64'd21}; req_a2 = {64'd200, 64'd2};
        req_unsign = 2'b11;
        req_valid = 2'b10;
        @(negedge clk);
        check("t4_grant1", 256'(req_ready), 256'(2'b10));
        tick(); req_valid = '0;
        tick();
        tick(); flush = 2'b10;
        @(negedge clk);
        check("t4_no_resp_T3", 256'(resp_valid), 256'(0));
        tick(); flush = '0; req_valid = 2'b01;
        @(negedge clk);
        check("t4_busy_T4", 256'({req_ready, resp_valid}), 256'(0));
        tick();
        @(negedge clk);
        check("t4_busy_T5", 256'({req_ready, resp_valid}), 256'(0));
        tick();
        @(negedge clk);
        check("t4_idle_grant_T6", 256'({req_ready, resp_valid}), 256'({2'b01, 2'b00}));
        tick();
        drain();
        do_reset();

        // Multiplier never answers: error pulse 16 cycles after ISSUE.
        stub_en = 1'b0;
        req_valid = 2'b01;
        @(negedge clk);
        check("t5_grant", 256'(req_ready), 256'(2'b01));
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            if (c == 17) req_valid = 2'b10;
            @(negedge clk);
            check($sformatf("t5_err_T%0d", c), 256'(err), 256'(c == 17));
            if (c == 17) check("t5_busy_T17", 256'(req_ready), 256'(0));
            if (c == 18) check("t5_idle_T18", 256'(req_ready), 256'(2'b10));
        end
        tick();
        do_reset();

        // Reset during WAIT, then a late result that must be ignored.
        req_a1 = {64'd0, 64'h1234}; req_a2 = {64'd0, 64'd5}; req_unsign = 2'b01;
        req_valid = 2'b01;
        @(negedge clk);
        check("t6_grant", 256'(req_ready), 256'(2'b01));
        tick(); req_valid = '0;
        tick();
        tick(); nrst = 1'b0;
        tick(); nrst = 1'b1;
        @(negedge clk);
        check("t6_reset_outputs", 256'({req_ready, mul_ena, mul_a1, mul_a2, mul_unsign, mul_high,
                                        mul_rv32, resp_valid, resp_data, err}), 256'(0));
        tick(); man_valid = 1'b1; man_res = 64'hDEAD_BEEF;
        tick(); man_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t6_late_ignored%0d", c), 256'({resp_valid, mul_ena}), 256'(0));
            tick();
        end
        stub_en = 1'b1;
        do_reset();

        // Randomized traffic with random latency and random accept back-pressure.
        arb_chk = 1'b1; stub_rand = 1'b1;
        pending = '0;
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (hs_mask[i]) begin
                    pending[i]   = 1'b0;
                    req_valid[i] = 1'b0;
                end
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i]   = 1'b1;
                    req_valid[i] = 1'b1;
                    req_a1[i*XLEN +: XLEN] = {$urandom, $urandom};
                    req_a2[i*XLEN +: XLEN] = {$urandom, $urandom};
                    req_unsign[i] = 1'($urandom);
                    req_high[i]   = 1'($urandom);
                    req_rv32[i]   = 1'($urandom);
                end
            end
            resp_ready = NREQ'($urandom);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
